pwm_deadtime_core: RTL and testbench

PWM_DEADTIME_CORE -- requirements
Module: pwm_deadtime_core

---
 rtl/pwm_dt_pkg.sv | 25 ++
 rtl/pwm_dt_channel.sv | 89 ++++++++
 rtl/pwm_deadtime_core.sv | 103 ++++++++++
 tb/tb_pwm_deadtime_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg
// Shared definitions for the dead-time PWM core: the per-channel state
// encoding, the slot register map and the dead-time reset value.
// Optional feature macro used by the core: PWM_DT_FAULT_EN.
package pwm_dt_pkg;

  // Channel state: both dead-time states keep both gates off.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_DT_LH = 3'd2,
    ST_HI    = 3'd3,
    ST_DT_HL = 3'd4
  } ch_state_t;

  // Slot register map
  localparam logic [4:0] ADDR_DT        = 5'h00;
  localparam logic [4:0] ADDR_EN        = 5'h01;
  localparam logic [4:0] ADDR_STATUS    = 5'h02;
  localparam logic [4:0] ADDR_FAULT_CLR = 5'h03;

  // Dead-time value after reset (cycles of extra off time)
  localparam int DT_RESET = 16;

endpackage

// File: rtl/pwm_dt_channel.sv
// pwm_dt_channel
// One complementary output channel: an FSM plus a dead-time down-counter
// that inserts dt+1 both-off cycles between the high and low gate drives.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   run          - channel enabled and not halted; 0 forces IDLE
//   dt           - dead-time value loaded on entry to a dead-time state
//   pwm          - raw PWM input for this channel
//   gate_hi      - high-side gate drive (only in HI)
//   gate_lo      - low-side gate drive (only in LO)
module pwm_dt_channel
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [DT_W-1:0] dt,
  input  logic            pwm,
  output logic            gate_hi,
  output logic            gate_lo
);

  ch_state_t       state, next_state;
  logic [DT_W-1:0] cnt, next_cnt;

  // State and counter registers; reset abandons any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic. The dead-time value is sampled only on entry to a
  // dead-time state, so a later dt write never disturbs a running count.
  // A pwm reversal during dead time returns straight to the gate that was
  // on before, since the opposite gate has not been driven yet.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (!run) begin
      next_state = ST_IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          next_state = pwm ? ST_DT_LH : ST_DT_HL;
          next_cnt   = dt;
        end
        ST_LO: begin
          if (pwm) begin
            next_state = ST_DT_LH;
            next_cnt   = dt;
          end
        end
        ST_HI: begin
          if (!pwm) begin
            next_state = ST_DT_HL;
            next_cnt   = dt;
          end
        end
        ST_DT_LH: begin
          if (!pwm)            next_state = ST_LO;
          else if (cnt == '0)  next_state = ST_HI;
          else                 next_cnt   = cnt - DT_W'(1);
        end
        ST_DT_HL: begin
          if (pwm)             next_state = ST_HI;
          else if (cnt == '0)  next_state = ST_LO;
          else                 next_cnt   = cnt - DT_W'(1);
        end
        default: begin
          next_state = ST_IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Gates decode from registered state only, so they can never overlap.
  assign gate_hi = (state == ST_HI);
  assign gate_lo = (state == ST_LO);

endmodule

// File: rtl/pwm_deadtime_core.sv
// pwm_deadtime_core
// Dead-time insertion for CH complementary PWM channels with a small slot
// register interface (dead time, channel enables, fault status/clear).
// Optional feature macro: PWM_DT_FAULT_EN adds a synchronous fault input
// and a fault latch that holds every channel in IDLE until cleared.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   cs, read, write, reg_addr, wr_data, rd_data - slot register access
//   pwm_in         - raw PWM, one bit per channel
//   fault          - (PWM_DT_FAULT_EN only) active-high fault request
//   gate_hi/gate_lo- high-side / low-side gate drives per channel
module pwm_deadtime_core
  import pwm_dt_pkg::*;
#(
  parameter int CH   = 6,
  parameter int DT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    reg_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CH-1:0] pwm_in,
`ifdef PWM_DT_FAULT_EN
  input  logic          fault,
`endif
  output logic [CH-1:0] gate_hi,
  output logic [CH-1:0] gate_lo
);

  logic [DT_W-1:0] dt_reg;
  logic [CH-1:0]   en_reg;
  logic            fault_latched;
  logic            halt;
  logic            wr_en;

  assign wr_en = cs & write;

  // The read strobe and upper address/data bits carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{read, reg_addr[4:2], wr_data};

  // Dead-time and enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dt_reg <= DT_W'(DT_RESET);
      en_reg <= '0;
    end else if (wr_en) begin
      case (reg_addr[1:0])
        ADDR_DT[1:0]: dt_reg <= wr_data[DT_W-1:0];
        ADDR_EN[1:0]: en_reg <= wr_data[CH-1:0];
        default: ;
      endcase
    end
  end

`ifdef PWM_DT_FAULT_EN
  // Fault latch: a live fault always wins over a clear request.
  always_ff @(posedge clk) begin
    if (reset)
      fault_latched <= 1'b0;
    else if (fault)
      fault_latched <= 1'b1;
    else if (wr_en && reg_addr[1:0] == ADDR_FAULT_CLR[1:0])
      fault_latched <= 1'b0;
  end

  // Raw fault is included so channels drop on the same edge the latch sets.
  assign halt = fault | fault_latched;
`else
  assign fault_latched = 1'b0;
  assign halt          = 1'b0;
`endif

  // Combinational read mux, zero-extended; the clear address reads 0.
  always_comb begin
    rd_data = '0;
    case (reg_addr[1:0])
      ADDR_DT[1:0]:     rd_data[DT_W-1:0] = dt_reg;
      ADDR_EN[1:0]:     rd_data[CH-1:0]   = en_reg;
      ADDR_STATUS[1:0]: rd_data[0]        = fault_latched;
      default:          rd_data           = '0;
    endcase
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_dt_channel #(
      .DT_W(DT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .run     (en_reg[i] & ~halt),
      .dt      (dt_reg),
      .pwm     (pwm_in[i]),
      .gate_hi (gate_hi[i]),
      .gate_lo (gate_lo[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime_core.sv
// tb_pwm_deadtime_core
// Self-checking bench for pwm_deadtime_core. Expected gate words
// {gate_hi, gate_lo} are queued as stimulus is applied and popped at each
// falling clock edge. Fault scenario compiled only with PWM_DT_FAULT_EN.
module tb_pwm_deadtime_core;

  localparam int CH   = 6;
  localparam int DT_W = 16;

  localparam logic [2*CH-1:0] EXP_OFF = 12'h000;
  localparam logic [2*CH-1:0] EXP_LO0 = 12'h001;
  localparam logic [2*CH-1:0] EXP_HI0 = 12'h040;

  logic          clk;
  logic          reset;
  logic          cs;
  logic          read;
  logic          write;
  logic [4:0]    reg_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [CH-1:0] pwm_in;
`ifdef PWM_DT_FAULT_EN
  logic          fault;
`endif
  logic [CH-1:0] gate_hi;
  logic [CH-1:0] gate_lo;

  logic [2*CH-1:0] exp_q[$];
  logic [2*CH-1:0] exp_w;
  logic [2*CH-1:0] obs;
  int compared;
  int mismatched;

  pwm_deadtime_core #(.CH(CH), .DT_W(DT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .pwm_in   (pwm_in),
`ifdef PWM_DT_FAULT_EN
    .fault    (fault),
`endif
    .gate_hi  (gate_hi),
    .gate_lo  (gate_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One register write, driven at a falling edge, committed at the next rise.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    cs       = 1'b1;
    write    = 1'b1;
    reg_addr = a;
    wr_data  = d;
    @(negedge clk);
    cs    = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(EXP_OFF);
    obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
    if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL reset_gates: observed=%h expected=%h", obs, exp_w); end
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(EXP_OFF);
    obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
    if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL post_reset_gates: observed=%h expected=%h", obs, exp_w); end
    reg_addr = 5'h00; #1; compared++;
    if (rd_data !== 32'd16) begin mismatched++; $display("[TB] FAIL reset_dt: observed=%h expected=%h", rd_data, 32'd16); end
    reg_addr = 5'h01; #1; compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_en: observed=%h expected=%h", rd_data, 32'd0); end
    reg_addr = 5'h02; #1; compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_status: observed=%h expected=%h", rd_data, 32'd0); end
    reg_addr = 5'h03; #1; compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL read_clr_addr: observed=%h expected=%h", rd_data, 32'd0); end
  endtask

  task automatic test_registers();
    @(negedge clk);
    write_reg(5'h00, 32'hABCD_1234);
    reg_addr = 5'h00; #1; compared++;
    if (rd_data !== 32'h0000_1234) begin mismatched++; $display("[TB] FAIL dt_readback: observed=%h expected=%h", rd_data, 32'h0000_1234); end
    @(negedge clk);
    write_reg(5'h01, 32'hFFFF_FFFF);
    reg_addr = 5'h01; #1; compared++;
    if (rd_data !== 32'h0000_003F) begin mismatched++; $display("[TB] FAIL en_readback: observed=%h expected=%h", rd_data, 32'h0000_003F); end
    @(negedge clk);
    write_reg(5'h01, 32'h0);
    reg_addr = 5'h01; #1; compared++;
    if (rd_data !== 32'h0) begin mismatched++; $display("[TB] FAIL en_clear_readback: observed=%h expected=%h", rd_data, 32'h0); end
    @(negedge clk);
  endtask

  // dt=4: low gate drops one cycle after pwm rises, 5 off cycles, then high.
  task automatic test_deadtime_basic();
    write_reg(5'h00, 32'd4);
    pwm_in = '0;
    write_reg(5'h01, 32'h1);
    repeat (12) @(negedge clk);
    exp_q.push_back(EXP_LO0);
    obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
    if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL basic_start_lo: observed=%h expected=%h", obs, exp_w); end
    pwm_in[0] = 1'b1;
    repeat (5) exp_q.push_back(EXP_OFF);
    repeat (3) exp_q.push_back(EXP_HI0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL basic_cycle%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
  endtask

  // dt=0 with pwm toggling every 3 cycles: one off cycle per transition.
  task automatic test_toggle_dt0();
    write_reg(5'h00, 32'd0);
    for (int t = 0; t < 5; t++) begin
      pwm_in[0] = ~pwm_in[0];
      exp_q.push_back(EXP_OFF);
      repeat (2) exp_q.push_back(pwm_in[0] ? EXP_HI0 : EXP_LO0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
        if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL toggle%0d_cycle%0d: observed=%h expected=%h", t, k, obs, exp_w); end
        compared++;
        if ((gate_hi & gate_lo) !== '0) begin mismatched++; $display("[TB] FAIL overlap: observed=%h expected=%h", gate_hi & gate_lo, 6'h0); end
      end
    end
  endtask

  // dt=10, 2-cycle pwm pulse from LO aborts the dead time back to LO.
  task automatic test_glitch_abort();
    write_reg(5'h00, 32'd10);
    pwm_in[0] = 1'b1;
    repeat (2) exp_q.push_back(EXP_OFF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL glitch_pulse%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
    pwm_in[0] = 1'b0;
    repeat (3) exp_q.push_back(EXP_LO0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL glitch_return%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
  endtask

  // Enable cleared in HI drops the gates; re-enable re-enters through IDLE.
  task automatic test_enable_clear();
    write_reg(5'h00, 32'd2);
    pwm_in[0] = 1'b1;
    repeat (3) exp_q.push_back(EXP_OFF);
    repeat (2) exp_q.push_back(EXP_HI0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL en_rise%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
    write_reg(5'h01, 32'h0);
    exp_q.push_back(EXP_HI0);
    obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
    if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL en_clear_same: observed=%h expected=%h", obs, exp_w); end
    repeat (2) exp_q.push_back(EXP_OFF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL en_cleared%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
    write_reg(5'h01, 32'h1);
    repeat (4) exp_q.push_back(EXP_OFF);
    repeat (2) exp_q.push_back(EXP_HI0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL reenable%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
  endtask

`ifdef PWM_DT_FAULT_EN
  // One-cycle fault in HI latches and halts; clear only succeeds with fault=0.
  task automatic test_fault();
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    repeat (3) exp_q.push_back(EXP_OFF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL fault_hold%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
    reg_addr = 5'h02; #1; compared++;
    if (rd_data !== 32'd1) begin mismatched++; $display("[TB] FAIL fault_status: observed=%h expected=%h", rd_data, 32'd1); end
    @(negedge clk);
    fault = 1'b1;
    write_reg(5'h03, 32'h0);
    fault = 1'b0;
    reg_addr = 5'h02; #1; compared++;
    if (rd_data !== 32'd1) begin mismatched++; $display("[TB] FAIL clear_blocked: observed=%h expected=%h", rd_data, 32'd1); end
    @(negedge clk);
    write_reg(5'h03, 32'h0);
    reg_addr = 5'h02; #1; compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL clear_status: observed=%h expected=%h", rd_data, 32'd0); end
    repeat (4) exp_q.push_back(EXP_OFF);
    repeat (2) exp_q.push_back(EXP_HI0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL fault_reentry%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
  endtask
`endif

  // Reset in the middle of a dt=20 count; afterwards a fresh dt=16 count.
  task automatic test_reset_mid_dt();
    write_reg(5'h00, 32'd20);
    pwm_in[0] = 1'b0;
    repeat (4) exp_q.push_back(EXP_OFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL middt%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(EXP_OFF);
    obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
    if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL middt_reset_gates: observed=%h expected=%h", obs, exp_w); end
    reg_addr = 5'h00; #1; compared++;
    if (rd_data !== 32'd16) begin mismatched++; $display("[TB] FAIL middt_reset_dt: observed=%h expected=%h", rd_data, 32'd16); end
    reg_addr = 5'h01; #1; compared++;
    if (rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL middt_reset_en: observed=%h expected=%h", rd_data, 32'd0); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    write_reg(5'h01, 32'h1);
    repeat (18) exp_q.push_back(EXP_OFF);
    repeat (2) exp_q.push_back(EXP_LO0);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      obs = {gate_hi, gate_lo}; exp_w = exp_q.pop_front(); compared++;
      if (obs !== exp_w) begin mismatched++; $display("[TB] FAIL post_reset_dt%0d: observed=%h expected=%h", k, obs, exp_w); end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    cs         = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    reg_addr   = '0;
    wr_data    = '0;
    pwm_in     = '0;
`ifdef PWM_DT_FAULT_EN
    fault      = 1'b0;
`endif
    test_reset();
    test_registers();
    test_deadtime_basic();
    test_toggle_dt0();
    test_glitch_abort();
    test_enable_clear();
`ifdef PWM_DT_FAULT_EN
    test_fault();
`endif
    test_reset_mid_dt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case a scenario ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
